iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//  Multi-cycle shift unit for the EX stage: SLL, SRL, SRA by a 5-bit amount.
//  Complements the fixed left-shift helpers with right/arithmetic shifts.
//  Shifts up to STEP bits per cycle, trading latency for area.
//  Uses a start/busy/done handshake; the hazard unit stalls on busy.
// PARAMETERS
//  WIDTH    32  data width
//  SHAMT_W  5   shift-amount width (WIDTH == 2**SHAMT_W)
//  STEP     1   max bits shifted per cycle; one of 1,2,4,8
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      request; accepted only when busy==0
//  op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROTR (see CONFIGURATION)
//  a       in   WIDTH  operand, sampled on the accept edge
//  shamt   in   SHAMT_W shift amount, sampled on the accept edge
//  busy    out  1      high while a shift is in progress
//  done    out  1      one-cycle pulse; y is valid this cycle
//  y       out  WIDTH  result; held until the next done
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, y=0, internal regs cleared.
//   Reset mid-shift aborts the operation; no done pulse is issued.
//  FSM: IDLE, SHIFT, DONE.
//   IDLE/DONE + start: latch a, op, rem=shamt.
//     Go to DONE if shamt==0, else to SHIFT.
//   IDLE/DONE, no start -> IDLE.
//   SHIFT: k=min(STEP,rem); shift the working reg by k; rem-=k.
//     Go to DONE when the new rem==0, else stay in SHIFT.
//  Outputs:
//   busy=1 only in SHIFT. start is accepted in IDLE and DONE,
//    so back-to-back ops are allowed.
//   done=1 only in DONE. y updates with the value shown in the DONE cycle.
//  Latency: accept edge at cycle 0; done in cycle 1+ceil(shamt/STEP).
//  start while busy: ignored; operands and the in-flight op are unaffected.
//  Arithmetic: SLL/SRL fill with 0. SRA fills with the bit a[WIDTH-1]
//   latched at accept; shamt=31 SRA of a negative value gives all ones.
//  Results are modulo WIDTH bits; no overflow flag.
//  rem never underflows: k<=rem always. shamt=0 returns a unchanged.
//  op/a/shamt changes after the accept edge have no effect.
// CONFIGURATION
//  ITER_SHIFTER_ROTR_EN
//   Defined: op=11 rotates right; bits leaving bit 0 enter bit WIDTH-1.
//   Undefined: op=11 behaves exactly as SRL; no rotate logic is built.
// TESTING (STEP=1 unless noted)
//  SLL a=0x00000001 shamt=31 -> done at cycle 32, y=0x80000000, busy for cycles 1..31.
//  SRA a=0x80000000 shamt=4 -> done at cycle 5, y=0xF8000000; SRL same -> 0x08000000.
//  shamt=0, any op, a=0xDEADBEEF -> done at cycle 1, y=0xDEADBEEF, busy never high.
//  start pulsed at cycle 2 of an SLL-by-8 with different a -> ignored; original result at cycle 9.
//  reset asserted at cycle 3 of an SRL-by-10 -> busy=done=0 and y=0 immediately; no later done.
//  STEP=4, SRL a=0xF0000000 shamt=5 -> done at cycle 3, y=0x07800000.
//  ROTR_EN: op=11 a=0x00000001 shamt=1 -> y=0x80000000.
//   Without ROTR_EN the same stimulus gives y=0x00000000.

Source files
------------

// File: rtl/iter_shifter.sv
// Iterative SLL/SRL/SRA shifter: up to STEP bits per cycle, start/busy/done handshake.
// Optional rotate-right on op=11 when ITER_SHIFTER_ROTR_EN is defined (otherwise op=11 acts as SRL).
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef ITER_SHIFTER_ROTR_EN
  localparam logic [1:0] OP_ROTR = 2'b11;
`endif
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t               r_state;
  logic [WIDTH-1:0]     r_work;
  logic [WIDTH-1:0]     r_y;
  logic [SHAMT_W-1:0]   r_rem;
  logic [1:0]           r_op;
  logic                 r_sign;

  logic [SHAMT_W-1:0]   w_k;
  logic [SHAMT_W-1:0]   w_rem_next;
  logic [WIDTH-1:0]     w_fill_mask;
  logic [WIDTH-1:0]     w_shifted;
`ifdef ITER_SHIFTER_ROTR_EN
  logic [2*WIDTH-1:0]   w_rot;
`endif

  // k = min(STEP, rem); rem is never below k, so it cannot underflow.
  assign w_k         = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_rem_next  = r_rem - w_k;
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_k);

  always_comb begin
    w_shifted = r_work >> w_k;
`ifdef ITER_SHIFTER_ROTR_EN
    w_rot = {r_work, r_work} >> w_k;
`endif
    case (r_op)
      OP_SLL: w_shifted = r_work << w_k;
      OP_SRA: w_shifted = (r_work >> w_k) | (r_sign ? w_fill_mask : '0);
`ifdef ITER_SHIFTER_ROTR_EN
      OP_ROTR: w_shifted = w_rot[WIDTH-1:0];
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_y     <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_sign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_work <= a;
            r_op   <= op;
            r_sign <= a[WIDTH-1];
            r_rem  <= shamt;
            if (shamt == '0) begin
              r_state <= S_DONE;
              r_y     <= a;
            end else begin
              r_state <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= S_DONE;
            r_y     <= w_shifted;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign y    = r_y;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: a STEP=1 and a STEP=4 instance, directed table, corner sequences, random ops.
module tb_iter_shifter;

  logic        clk;
  logic        reset;
  logic        st  [2];
  logic [1:0]  opv [2];
  logic [31:0] av  [2];
  logic [4:0]  shv [2];
  logic        busy[2];
  logic        done[2];
  logic [31:0] yv  [2];

  int n_vec;
  int n_err;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(st[0]), .op(opv[0]), .a(av[0]), .shamt(shv[0]),
    .busy(busy[0]), .done(done[0]), .y(yv[0])
  );

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(st[1]), .op(opv[1]), .a(av[1]), .shamt(shv[1]),
    .busy(busy[1]), .done(done[1]), .y(yv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp_y;
    int          exp_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_y(input logic [1:0] op, input logic [31:0] a, input int sh);
    logic [63:0] t;
    case (op)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: return $unsigned($signed(a) >>> sh);
      default: begin
`ifdef ITER_SHIFTER_ROTR_EN
        t = {a, a} >> sh;
        return t[31:0];
`else
        t = {32'h0, a} >> sh;
        return t[31:0];
`endif
      end
    endcase
  endfunction

  function automatic int ref_lat(input int sh, input int step);
    return 1 + (sh + step - 1) / step;
  endfunction

  // Call just after a negedge; returns #1 after the accept edge with inputs scrambled.
  task automatic start_op(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
    st[sel]  = 1'b1;
    opv[sel] = op;
    av[sel]  = a;
    shv[sel] = sh;
    @(posedge clk);
    #1;
    st[sel]  = 1'b0;
    opv[sel] = 2'($urandom);
    av[sel]  = $urandom;
    shv[sel] = 5'($urandom);
  endtask

  // Returns at the negedge of the done cycle; inj>0 pulses a spurious start in that busy cycle.
  task automatic wait_done(input int sel, input logic [31:0] exp_y, input int exp_lat,
                           input int inj, input string name);
    int  n = 0;
    bit  seen = 0;
    bit  busy_ok = 1;
    bit  inj_on = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (inj_on) begin
        st[sel] = 1'b0;
        inj_on = 0;
      end
      if (done[sel]) begin
        seen = 1;
        if (busy[sel]) busy_ok = 0;
      end else begin
        if (!busy[sel]) busy_ok = 0;
        if (inj != 0 && n == inj) begin
          st[sel]  = 1'b1;
          opv[sel] = 2'($urandom);
          av[sel]  = ~exp_y ^ $urandom;
          shv[sel] = 5'($urandom);
          inj_on = 1;
        end
      end
    end
    if (!seen) $display("FAIL %s timeout: no done within %0d cycles", name, n);
    check({name, " latency"}, n, exp_lat);
    check({name, " y"}, yv[sel], exp_y);
    check({name, " busy-trace"}, {31'h0, busy_ok}, 32'h1);
  endtask

  task automatic post_check(input int sel, input logic [31:0] exp_y, input string name);
    @(negedge clk);
    check({name, " done-pulse"}, {31'h0, done[sel]}, 32'h0);
    check({name, " y-held"}, yv[sel], exp_y);
  endtask

  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input int inj, input string name);
    logic [31:0] e;
    int          l;
    e = ref_y(op, a, int'(sh));
    l = ref_lat(int'(sh), (sel == 0) ? 1 : 4);
    start_op(sel, op, a, sh);
    wait_done(sel, e, l, inj, name);
    post_check(sel, e, name);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rop;
    logic [4:0]  rsh;
    int          rinj;
    bit          late_done;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; opv[i] = 2'b00; av[i] = '0; shv[i] = '0;
    end

    tbl[0]  = '{0, 2'b00, 32'h00000001, 5'd31, 32'h80000000, 32};
    tbl[1]  = '{0, 2'b10, 32'h80000000, 5'd4,  32'hF8000000, 5};
    tbl[2]  = '{0, 2'b01, 32'h80000000, 5'd4,  32'h08000000, 5};
    tbl[3]  = '{0, 2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    tbl[4]  = '{0, 2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    tbl[5]  = '{0, 2'b10, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    tbl[6]  = '{0, 2'b11, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
`ifdef ITER_SHIFTER_ROTR_EN
    tbl[7]  = '{0, 2'b11, 32'h00000001, 5'd1,  32'h80000000, 2};
`else
    tbl[7]  = '{0, 2'b11, 32'h00000001, 5'd1,  32'h00000000, 2};
`endif
    tbl[8]  = '{0, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 32};
    tbl[9]  = '{0, 2'b01, 32'hFFFFFFFF, 5'd31, 32'h00000001, 32};
    tbl[10] = '{1, 2'b01, 32'hF0000000, 5'd5,  32'h07800000, 3};
    tbl[11] = '{1, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9};

    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy[0]}, 32'h0);
    check("reset done", {31'h0, done[0]}, 32'h0);
    check("reset y", yv[0], 32'h0);
    check("reset y step4", yv[1], 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].sh);
      wait_done(tbl[i].sel, tbl[i].exp_y, tbl[i].exp_lat, 0, $sformatf("tbl[%0d]", i));
      post_check(tbl[i].sel, tbl[i].exp_y, $sformatf("tbl[%0d]", i));
    end

    // Spurious start in cycle 2 of an SLL-by-8 must be ignored.
    start_op(0, 2'b00, 32'h000000FF, 5'd8);
    wait_done(0, 32'h0000FF00, 9, 2, "ignore-start");
    post_check(0, 32'h0000FF00, "ignore-start");

    // Back-to-back: second op accepted in the done cycle of the first.
    start_op(0, 2'b10, 32'h80000010, 5'd3);
    wait_done(0, 32'hF0000002, 4, 0, "b2b-first");
    start_op(0, 2'b00, 32'h00000003, 5'd2);
    wait_done(0, 32'h0000000C, 3, 0, "b2b-second");
    post_check(0, 32'h0000000C, "b2b-second");

    // Reset at cycle 3 of an SRL-by-10 aborts with no later done.
    start_op(0, 2'b01, 32'hFFFF0000, 5'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", {31'h0, busy[0]}, 32'h0);
    check("abort done", {31'h0, done[0]}, 32'h0);
    check("abort y", yv[0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    late_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] || busy[0]) late_done = 1;
    end
    check("abort no-done", {31'h0, late_done}, 32'h0);

    for (int i = 0; i < 150; i++) begin
      ra   = $urandom;
      rop  = 2'($urandom);
      rsh  = 5'($urandom);
      rinj = (rsh > 1 && $urandom_range(1, 0) == 1) ? $urandom_range(int'(rsh) - 1, 1) : 0;
      run_op(0, rop, ra, rsh, rinj, $sformatf("rnd1[%0d]", i));
    end

    for (int i = 0; i < 60; i++) begin
      ra   = $urandom;
      rop  = 2'($urandom);
      rsh  = 5'($urandom);
      rinj = (rsh > 4 && $urandom_range(1, 0) == 1) ? 1 : 0;
      run_op(1, rop, ra, rsh, rinj, $sformatf("rnd4[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
